elastic_buffer: RTL and testbench



---
 rtl/dataflow_pkg.sv | 8 +
 rtl/elastic_buffer_regfile.sv | 19 +
 rtl/elastic_buffer.sv | 54 +++++
 tb/tb_elastic_buffer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// dataflow_pkg: shared widths, types and sizing helpers for dataflow stages
package dataflow_pkg;
  localparam int DATA_W = 32;
  typedef logic signed [DATA_W-1:0] data_t;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/elastic_buffer_regfile.sv
// elastic_buffer_regfile: unreset DEPTH x WIDTH storage, one write port, async read
module elastic_buffer_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);
  logic signed [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/elastic_buffer.sv
// elastic_buffer: valid/ready FIFO stage with registered ready and registered data path
module elastic_buffer
  import dataflow_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [WIDTH-1:0]         arg0,
  input  logic                            arg1,
  input  logic                            arg2,
  output logic                            ret0,
  output logic signed [WIDTH-1:0]         ret1,
  output logic                            ret2,
  output logic [$clog2(DEPTH+1)-1:0]      ret3
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic rdy_q, push, pop;
  logic signed [WIDTH-1:0] rdata;
  elastic_buffer_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_rf (
    .clk(clk), .we(push), .waddr(wr_ptr_q), .wdata(arg0), .raddr(rd_ptr_q), .rdata(rdata)
  );
  // pointers wrap by explicit compare so non-power-of-two depths stay correct
  always_comb begin
    push     = arg1 & rdy_q;
    pop      = ret2 & arg2;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= count_d < FULL;
    end
  end
  assign ret0 = rdy_q;
  assign ret2 = count_q != '0;
  assign ret3 = count_q;
  assign ret1 = ret2 ? rdata : '0;
endmodule

// File: tb/tb_elastic_buffer.sv
// tb_elastic_buffer: directed checks on a depth-2 buffer and a scoreboarded depth-3 buffer
module tb_elastic_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [31:0] a0, b0;
  logic a1, a2, b1, b2;
  logic ar0, ar2, br0, br2;
  logic signed [31:0] ar1, br1;
  logic [1:0] ar3, br3;
  int checks = 0;
  int errors = 0;

  elastic_buffer #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .arg0(a0), .arg1(a1), .arg2(a2),
    .ret0(ar0), .ret1(ar1), .ret2(ar2), .ret3(ar3)
  );
  elastic_buffer #(.WIDTH(32), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .arg0(b0), .arg1(b1), .arg2(b2),
    .ret0(br0), .ret1(br1), .ret2(br2), .ret3(br3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a1 = 1'b1; a0 = 5; a2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ret0", ar0, 0); chk("rst_ret2", ar2, 0);
      chk("rst_ret1", ar1, 0); chk("rst_ret3", ar3, 0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_ret0", ar0, 1); chk("rel_ret2", ar2, 0);
    step();
    chk("rel_ret2b", ar2, 1); chk("rel_ret1", ar1, 5);
    a1 = 1'b0; a2 = 1'b1;
    step();
    chk("rel_drain", ar2, 0);
    a2 = 1'b0;
  endtask

  task automatic test_fill();
    a1 = 1'b1; a0 = -7;
    step();
    chk("fill_cnt1", ar3, 1); chk("fill_rdy1", ar0, 1); chk("fill_head1", ar1, -7);
    a0 = 9;
    step();
    chk("fill_cnt2", ar3, 2); chk("fill_rdy2", ar0, 0);
    a0 = 11;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_rdy", ar0, 0); chk("full_cnt", ar3, 2); chk("full_head", ar1, -7);
    end
  endtask

  task automatic test_drain();
    a2 = 1'b1; a1 = 1'b1; a0 = 11;
    chk("drain_pop1", ar1, -7);
    step();
    chk("drain_cnt1", ar3, 1); chk("drain_head1", ar1, 9); chk("drain_rdy1", ar0, 1);
    step();
    chk("drain_cnt2", ar3, 1); chk("drain_head2", ar1, 11);
    a1 = 1'b0;
    step();
    chk("drain_empty", ar2, 0); chk("drain_cnt3", ar3, 0);
  endtask

  task automatic test_stream();
    a1 = 1'b1; a2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a0 = i;
      step();
      chk("stream_data", ar1, i); chk("stream_cnt", ar3, 1); chk("stream_rdy", ar0, 1);
    end
    a1 = 1'b0;
    step();
    chk("stream_end", ar2, 0);
    a2 = 1'b0;
  endtask

  task automatic test_wrap_depth3();
    logic signed [31:0] q[$];
    logic signed [31:0] nxt;
    int beats_in = 0;
    int beats_out = 0;
    int cyc = 0;
    logic push, pop;
    nxt = 32'sh8000_0000;
    while (beats_out < 1000 && cyc < 20000) begin
      b1 = ($urandom % 2) == 1 && beats_in < 1000;
      b2 = ($urandom % 2) == 1;
      b0 = nxt;
      chk("w3_cnt", br3, q.size());
      chk("w3_valid", br2, q.size() != 0);
      chk("w3_rdy", br0, q.size() < 3);
      push = b1 & br0;
      pop = br2 & b2;
      if (pop) begin
        chk("w3_data", br1, q[0]);
        void'(q.pop_front());
        beats_out++;
      end
      if (push) begin
        q.push_back(nxt);
        beats_in++;
        nxt = (beats_in == 1) ? 32'sh7fff_ffff : $signed($urandom);
      end
      step();
      cyc++;
    end
    b1 = 1'b0; b2 = 1'b0;
    chk("w3_done", beats_out, 1000);
  endtask

  task automatic test_mid_reset();
    a2 = 1'b0; a1 = 1'b1; a0 = 1;
    step();
    a0 = 2;
    step();
    a1 = 1'b0;
    chk("mr_cnt_pre", ar3, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_ret2", ar2, 0); chk("mr_ret3", ar3, 0);
    chk("mr_ret0", ar0, 0); chk("mr_ret1", ar1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_rdy", ar0, 1); chk("mr_nostale", ar2, 0);
    a1 = 1'b1; a0 = 42; a2 = 1'b1;
    step();
    chk("mr_first_v", ar2, 1); chk("mr_first", ar1, 42);
    a1 = 1'b0;
    step();
    chk("mr_empty", ar2, 0);
    a2 = 1'b0;
  endtask

  initial begin
    a0 = 0; a1 = 0; a2 = 0; b0 = 0; b1 = 0; b2 = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_wrap_depth3();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
